issueque_ctrl: RTL and testbench

- Control sequencer for the 4-slot integer issue-queue shift register.
- Keeps a shadow copy of per-slot valid, operand-valid and source tags.
- Each cycle it selects the oldest ready slot for issue, collapses holes by shifting younger slots up, and captures CDB wakeups.
- Drives every enable_*/sel_* vector of the shift register; sits between dispatch, the CDB and the integer FU.

---
 rtl/issueque_ctrl_pkg.sv | 48 ++++
 rtl/issueque_ctrl_if.sv | 37 +++
 rtl/issueque_ctrl_wakeup_cmp.sv | 28 ++
 rtl/issueque_ctrl.sv | 111 +++++++++++
 tb/tb_issueque_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/issueque_ctrl_pkg.sv
// Shared types for the issue-queue controller: slot shadow record, enable bundle, oldest-ready pick.
// Latency: n/a (types and a pure function). Backpressure: n/a.
// Slot index i here always means physical slot i+1; higher index is older.
package issueque_pkg;

    localparam int DEPTH     = 4;
    localparam int TAG_WIDTH = 6;
    localparam int SLOT_W    = $clog2(DEPTH);
    localparam int OCC_W     = $clog2(DEPTH + 1);

    typedef logic [SLOT_W-1:0]    slot_idx_t;
    typedef logic [TAG_WIDTH-1:0] tag_t;
    typedef logic [DEPTH-1:0]     vec_t;
    typedef logic [OCC_W-1:0]     occ_t;

    typedef struct packed {
        logic valid;
        logic rs1v;
        logic rs2v;
        tag_t rs1_tag;
        tag_t rs2_tag;
    } slot_t;

    typedef struct packed {
        vec_t enable_valid;
        vec_t enable_opcode;
        vec_t enable_rd_tag;
        vec_t enable_rs1_tag;
        vec_t enable_rs2_tag;
        vec_t enable_rs1_data;
        vec_t enable_rs2_data;
        vec_t enable_rs1_valid;
        vec_t enable_rs2_valid;
        vec_t sel_rs1;
        vec_t sel_rs2;
    } en_vec_t;

    // Highest set bit wins; returns 0 when nothing is ready.
    function automatic slot_idx_t oldest_ready(input vec_t rdy);
        slot_idx_t idx;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) idx = slot_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/issueque_ctrl_if.sv
// Dispatch / CDB / FU handshake plus the shift-register control bundle.
// Latency: n/a (wiring only). Backpressure: dispatch_accept low means dispatch must hold and retry.
// master = controller side, slave = environment side.
interface issueque_ctrl_if;
    import issueque_pkg::*;

    logic      dispatch_enable;
    tag_t      dispatch_rs1_tag;
    tag_t      dispatch_rs2_tag;
    logic      dispatch_rs1_data_val;
    logic      dispatch_rs2_data_val;
    logic      CDB_valid;
    tag_t      CDB_tag;
    logic      issue_grant;

    logic      dispatch_accept;
    logic      issueque_full;
    logic      issue_req;
    slot_idx_t issue_slot;
    occ_t      occupancy;
    en_vec_t   ctl;

    modport master (
        input  dispatch_enable, dispatch_rs1_tag, dispatch_rs2_tag,
               dispatch_rs1_data_val, dispatch_rs2_data_val,
               CDB_valid, CDB_tag, issue_grant,
        output dispatch_accept, issueque_full, issue_req, issue_slot, occupancy, ctl
    );

    modport slave (
        output dispatch_enable, dispatch_rs1_tag, dispatch_rs2_tag,
               dispatch_rs1_data_val, dispatch_rs2_data_val,
               CDB_valid, CDB_tag, issue_grant,
        input  dispatch_accept, issueque_full, issue_req, issue_slot, occupancy, ctl
    );

endinterface

// File: rtl/issueque_ctrl_wakeup_cmp.sv
// Per-slot source mux (own slot or the younger neighbour when shifting) plus CDB tag compare.
// Latency: purely combinational. Backpressure: none.
// nxt is the shadow value this slot takes on the next edge, wakeups already folded in.
module issueque_wakeup_cmp
    import issueque_pkg::*;
(
    input  logic  shift,
    input  slot_t own,
    input  slot_t below,
    input  logic  cdb_valid,
    input  tag_t  cdb_tag,
    output slot_t nxt,
    output logic  match1,
    output logic  match2
);

    slot_t src;

    always_comb begin
        src    = shift ? below : own;
        match1 = cdb_valid & ~src.rs1v & (src.rs1_tag == cdb_tag);
        match2 = cdb_valid & ~src.rs2v & (src.rs2_tag == cdb_tag);
        nxt      = src;
        nxt.rs1v = src.rs1v | match1;
        nxt.rs2v = src.rs2v | match2;
    end

endmodule

// File: rtl/issueque_ctrl.sv
// Issue-queue sequencer: oldest-ready select, hole collapse toward the old end, CDB wakeup capture.
// Latency: controls are combinational from registered shadow state; shadow/occupancy update on the edge.
// Backpressure: dispatch_accept drops when no hole reaches slot 1; the FU stalls issue via issue_grant.
module issueque_ctrl
    import issueque_pkg::*;
(
    input logic            clk,
    input logic            reset,
    issueque_ctrl_if.master io
);

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];
    slot_t below  [DEPTH];
    logic  m1     [DEPTH];
    logic  m2     [DEPTH];
    occ_t  occ_q, occ_d;

    vec_t      ready, issued, hole, shift;
    logic      req_c, fire, accept_c;
    slot_idx_t slot_c;

    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = slot_q[i].valid & slot_q[i].rs1v & slot_q[i].rs2v;
        end
        req_c  = |ready;
        slot_c = oldest_ready(ready);
        fire   = req_c & io.issue_grant;

        issued = '0;
        if (fire) issued[slot_c] = 1'b1;

        hole  = '0;
        shift = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hole[i]  = ~slot_q[i].valid | issued[i];
            shift[i] = hole[i] | ((i < DEPTH - 1) ? shift[(i + 1) % DEPTH] : 1'b0);
        end

        below[0].valid   = io.dispatch_enable;
        below[0].rs1v    = io.dispatch_rs1_data_val;
        below[0].rs2v    = io.dispatch_rs2_data_val;
        below[0].rs1_tag = io.dispatch_rs1_tag;
        below[0].rs2_tag = io.dispatch_rs2_tag;
        // An issued instruction must not reappear one slot older when it is shifted past.
        for (int i = 1; i < DEPTH; i++) begin
            below[i]       = slot_q[i-1];
            below[i].valid = slot_q[i-1].valid & ~issued[i-1];
        end

        accept_c = shift[0] & io.dispatch_enable;
        occ_d    = occ_q + occ_t'(accept_c) - occ_t'(fire);
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gen_cmp
        issueque_wakeup_cmp u_cmp (
            .shift     (shift[g]),
            .own       (slot_q[g]),
            .below     (below[g]),
            .cdb_valid (io.CDB_valid),
            .cdb_tag   (io.CDB_tag),
            .nxt       (slot_d[g]),
            .match1    (m1[g]),
            .match2    (m2[g])
        );
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    always_comb begin
        io.ctl             = '0;
        io.dispatch_accept = 1'b0;
        io.issueque_full   = 1'b0;
        io.issue_req       = 1'b0;
        io.issue_slot      = '0;
        io.occupancy       = '0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                io.ctl.enable_valid[i]     = shift[i];
                io.ctl.enable_opcode[i]    = shift[i];
                io.ctl.enable_rd_tag[i]    = shift[i];
                io.ctl.enable_rs1_tag[i]   = shift[i];
                io.ctl.enable_rs2_tag[i]   = shift[i];
                io.ctl.enable_rs1_data[i]  = shift[i] | m1[i];
                io.ctl.enable_rs1_valid[i] = shift[i] | m1[i];
                io.ctl.enable_rs2_data[i]  = shift[i] | m2[i];
                io.ctl.enable_rs2_valid[i] = shift[i] | m2[i];
                io.ctl.sel_rs1[i]          = ~m1[i];
                io.ctl.sel_rs2[i]          = ~m2[i];
                io.issueque_full           = (i == 0) ? slot_q[i].valid
                                                      : (io.issueque_full & slot_q[i].valid);
            end
            io.dispatch_accept = accept_c;
            io.issue_req       = req_c;
            io.issue_slot      = slot_c;
            io.occupancy       = occ_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_issueque_ctrl.sv
// Directed bench for issueque_ctrl: hand-computed expectations for fill, issue/collapse, wakeup and reset.
module tb_issueque_ctrl;
    import issueque_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    issueque_ctrl_if io ();

    issueque_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        io.dispatch_enable       = 1'b0;
        io.dispatch_rs1_tag      = '0;
        io.dispatch_rs2_tag      = '0;
        io.dispatch_rs1_data_val = 1'b0;
        io.dispatch_rs2_data_val = 1'b0;
        io.CDB_valid             = 1'b0;
        io.CDB_tag               = '0;
        io.issue_grant           = 1'b0;
    endtask

    task automatic disp(input logic [5:0] t1, input logic [5:0] t2, input logic v1, input logic v2);
        io.dispatch_enable       = 1'b1;
        io.dispatch_rs1_tag      = t1;
        io.dispatch_rs2_tag      = t2;
        io.dispatch_rs1_data_val = v1;
        io.dispatch_rs2_data_val = v2;
    endtask

    task automatic cdb(input logic [5:0] t);
        io.CDB_valid = 1'b1;
        io.CDB_tag   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    logic [5:0] t1_tab [4];
    logic [5:0] t2_tab [4];

    initial begin
        // A, B, C, D land in slots 4, 3, 2, 1
        t1_tab = '{6'h01, 6'h15, 6'h2C, 6'h01};
        t2_tab = '{6'h02, 6'h16, 6'h2C, 6'h04};

        idle();
        disp(6'h3F, 6'h3F, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ",  64'(io.occupancy), 0);
        chk("rst_full", 64'(io.issueque_full), 0);
        chk("rst_req",  64'(io.issue_req), 0);
        chk("rst_en",   64'(io.ctl), 0);
        chk("rst_acc",  64'(io.dispatch_accept), 0);
        reset = 1'b1;
        idle();

        for (int i = 0; i < 4; i++) begin
            disp(t1_tab[i], t2_tab[i], 1'b0, 1'b0);
            #1;
            chk("fill_acc", 64'(io.dispatch_accept), 1);
            tick();
            chk("fill_occ",  64'(io.occupancy), 64'(i + 1));
            chk("fill_full", 64'(io.issueque_full), (i == 3) ? 64'd1 : 64'd0);
        end

        disp(6'h3F, 6'h3F, 1'b0, 1'b0);
        #1;
        chk("drop_acc", 64'(io.dispatch_accept), 0);
        chk("drop_env", 64'(io.ctl.enable_valid), 0);
        tick();
        chk("drop_occ", 64'(io.occupancy), 4);

        cdb(6'h16);
        #1;
        chk("w16_rs2d", 64'(io.ctl.enable_rs2_data), 4'b0100);
        chk("w16_rs1d", 64'(io.ctl.enable_rs1_data), 4'b0000);
        chk("w16_sel2", 64'(io.ctl.sel_rs2), 4'b1011);
        tick();
        chk("w16_req", 64'(io.issue_req), 0);

        // one tag wakes both operands of slot 2
        cdb(6'h2C);
        #1;
        chk("w2c_rs1d", 64'(io.ctl.enable_rs1_data), 4'b0010);
        chk("w2c_rs2d", 64'(io.ctl.enable_rs2_data), 4'b0010);
        chk("w2c_sel1", 64'(io.ctl.sel_rs1), 4'b1101);
        chk("w2c_env",  64'(io.ctl.enable_valid), 0);
        tick();
        chk("w2c_req",  64'(io.issue_req), 1);
        chk("w2c_slot", 64'(io.issue_slot), 1);

        disp(6'h07, 6'h31, 1'b0, 1'b0);
        io.issue_grant = 1'b1;
        #1;
        chk("iss_slot", 64'(io.issue_slot), 1);
        chk("iss_env",  64'(io.ctl.enable_valid), 4'b0011);
        chk("iss_eop",  64'(io.ctl.enable_opcode), 4'b0011);
        chk("iss_ert2", 64'(io.ctl.enable_rs2_tag), 4'b0011);
        chk("iss_acc",  64'(io.dispatch_accept), 1);
        tick();
        chk("iss_occ",  64'(io.occupancy), 4);
        chk("iss_full", 64'(io.issueque_full), 1);
        chk("iss_req",  64'(io.issue_req), 0);

        cdb(6'h15);
        #1;
        chk("w15_sel1", 64'(io.ctl.sel_rs1), 4'b1011);
        chk("w15_rs1d", 64'(io.ctl.enable_rs1_data), 4'b0100);
        chk("w15_rs1v", 64'(io.ctl.enable_rs1_valid), 4'b0100);
        chk("w15_env",  64'(io.ctl.enable_valid), 0);
        tick();
        chk("w15_req",  64'(io.issue_req), 1);
        chk("w15_slot", 64'(io.issue_slot), 2);

        // wakeup rides along with slot 1 shifting into slot 2
        cdb(6'h07);
        io.issue_grant = 1'b1;
        #1;
        chk("w07_slot", 64'(io.issue_slot), 2);
        chk("w07_env",  64'(io.ctl.enable_valid), 4'b0111);
        chk("w07_sel1", 64'(io.ctl.sel_rs1), 4'b1101);
        chk("w07_rs1v", 64'(io.ctl.enable_rs1_valid), 4'b0111);
        chk("w07_acc",  64'(io.dispatch_accept), 0);
        tick();
        chk("w07_occ",  64'(io.occupancy), 3);
        chk("w07_full", 64'(io.issueque_full), 0);
        chk("w07_req",  64'(io.issue_req), 0);

        cdb(6'h31);
        #1;
        chk("w31_rs2d", 64'(io.ctl.enable_rs2_data), 4'b0011);
        chk("w31_sel2", 64'(io.ctl.sel_rs2), 4'b1101);
        chk("w31_env",  64'(io.ctl.enable_valid), 4'b0001);
        tick();
        chk("w31_req",  64'(io.issue_req), 1);
        chk("w31_slot", 64'(io.issue_slot), 1);

        disp(6'h3A, 6'h22, 1'b1, 1'b0);
        cdb(6'h22);
        #1;
        chk("dw_sel2", 64'(io.ctl.sel_rs2), 4'b1110);
        chk("dw_rs2v", 64'(io.ctl.enable_rs2_valid), 4'b0001);
        chk("dw_acc",  64'(io.dispatch_accept), 1);
        tick();
        chk("dw_occ",  64'(io.occupancy), 4);
        chk("dw_full", 64'(io.issueque_full), 1);
        chk("dw_slot", 64'(io.issue_slot), 1);

        io.issue_grant = 1'b1;
        #1;
        chk("ie_env", 64'(io.ctl.enable_valid), 4'b0011);
        tick();
        chk("ie_req",  64'(io.issue_req), 1);
        chk("ie_slot", 64'(io.issue_slot), 1);
        chk("ie_occ",  64'(io.occupancy), 3);

        io.issue_grant = 1'b1;
        tick();
        chk("if_occ", 64'(io.occupancy), 2);
        chk("if_req", 64'(io.issue_req), 0);

        // one tag wakes slots 3 and 4 together
        cdb(6'h01);
        #1;
        chk("w01_rs1d", 64'(io.ctl.enable_rs1_data), 4'b1111);
        chk("w01_sel1", 64'(io.ctl.sel_rs1), 4'b0011);
        tick();
        cdb(6'h04);
        #1;
        chk("w04_rs2d", 64'(io.ctl.enable_rs2_data), 4'b0111);
        tick();
        chk("w04_req",  64'(io.issue_req), 1);
        chk("w04_slot", 64'(io.issue_slot), 2);

        #2;
        reset = 1'b0;
        #1;
        chk("arst_occ",  64'(io.occupancy), 0);
        chk("arst_req",  64'(io.issue_req), 0);
        chk("arst_full", 64'(io.issueque_full), 0);
        chk("arst_en",   64'(io.ctl), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk("post_occ", 64'(io.occupancy), 0);
        chk("post_req", 64'(io.issue_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
